// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// data_mem_ctrl : single-port data memory controller with in-order responses
// Revision      : 1.0
// ============================================================================
module data_mem_ctrl #(
  parameter int imem_addr_width_p = 10,
  parameter int dmem_addr_width_p = 10,
  parameter int latency_p         = 2,
  parameter int resp_fifo_depth_p = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_v_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_mask_i,
  output logic        resp_v_o,
  input  logic        resp_yumi_i,
  output logic [31:0] resp_data_o,
  output logic        resp_we_o,
  output logic        resp_err_o,
  output logic        exception_o,
  output logic [3:0]  outstanding_o
);
  localparam int words_lp = 1 << dmem_addr_width_p;
  localparam int ptr_w_lp = $clog2(resp_fifo_depth_p);
  localparam int dstg_lp  = (latency_p > 1) ? latency_p - 1 : 1;
  localparam logic [3:0]          depth_lp    = 4'(resp_fifo_depth_p);
  localparam logic [ptr_w_lp-1:0] ptr_last_lp = ptr_w_lp'(resp_fifo_depth_p - 1);

  if (imem_addr_width_p < 1 || dmem_addr_width_p < 1 || dmem_addr_width_p > 30 ||
      latency_p < 1 || latency_p > 4 ||
      resp_fifo_depth_p < 2 || resp_fifo_depth_p > 8) begin : g_bad_params
    $error("data_mem_ctrl: illegal parameter combination");
  end

  logic [31:0] mem [words_lp];
  logic [31:0] mem_rdata_q;

  logic [latency_p-1:0] pipe_v_q, pipe_v_d, pipe_we_q, pipe_we_d, pipe_err_q, pipe_err_d;
  logic [31:0] pipe_data_q [dstg_lp];
  logic [31:0] pipe_data_d [dstg_lp];

  logic [31:0]                  fifo_data_q [resp_fifo_depth_p];
  logic [resp_fifo_depth_p-1:0] fifo_we_q, fifo_err_q;
  logic [ptr_w_lp-1:0]          wptr_q, wptr_d, rptr_q, rptr_d;
  logic [3:0]                   count_q, count_d, outst_q, outst_d;
  logic                         ready_q, ready_d, exc_q, exc_d;

  logic                         accept, acc_err, push, pop;
  logic [dmem_addr_width_p-1:0] idx;
  logic [31:0]                  last_data, push_data;

  // Ready depends only on registered credit state, masked while reset is held.
  assign req_ready_o = ready_q & reset;
  assign accept      = req_v_i & req_ready_o;
  assign acc_err     = (req_addr_i[1:0] != 2'b00) |
                       ((req_addr_i >> (dmem_addr_width_p + 2)) != 32'd0);
  assign idx         = req_addr_i[dmem_addr_width_p+1:2];
  assign pop         = resp_yumi_i & resp_v_o;

  assign push      = pipe_v_q[latency_p-1];
  assign last_data = (latency_p == 1) ? mem_rdata_q : pipe_data_q[dstg_lp-1];
  assign push_data = (pipe_we_q[latency_p-1] | pipe_err_q[latency_p-1]) ? 32'd0 : last_data;

  always_comb begin
    pipe_v_d[0]    = accept;
    pipe_we_d[0]   = req_we_i;
    pipe_err_d[0]  = acc_err;
    for (int i = 1; i < latency_p; i++) begin
      pipe_v_d[i]   = pipe_v_q[i-1];
      pipe_we_d[i]  = pipe_we_q[i-1];
      pipe_err_d[i] = pipe_err_q[i-1];
    end
    pipe_data_d[0] = mem_rdata_q;
    for (int j = 1; j < dstg_lp; j++) begin
      pipe_data_d[j] = pipe_data_q[j-1];
    end
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) wptr_d = (wptr_q == ptr_last_lp) ? '0 : wptr_q + 1'b1;
    if (pop)  rptr_d = (rptr_q == ptr_last_lp) ? '0 : rptr_q + 1'b1;
    count_d = count_q + {3'b000, push} - {3'b000, pop};
    outst_d = outst_q + {3'b000, accept} - {3'b000, pop};
    ready_d = (outst_d < depth_lp);
    exc_d   = exc_q | (accept & acc_err);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pipe_v_q   <= '0;
      pipe_we_q  <= '0;
      pipe_err_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      outst_q    <= '0;
      ready_q    <= 1'b0;
      exc_q      <= 1'b0;
    end else begin
      pipe_v_q   <= pipe_v_d;
      pipe_we_q  <= pipe_we_d;
      pipe_err_q <= pipe_err_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      ready_q    <= ready_d;
      exc_q      <= exc_d;
    end
  end

  // Payload storage needs no reset: every consumer is qualified by a valid.
  always_ff @(posedge clk) begin
    for (int j = 0; j < dstg_lp; j++) begin
      pipe_data_q[j] <= pipe_data_d[j];
    end
    if (push) begin
      fifo_data_q[wptr_q] <= push_data;
      fifo_we_q[wptr_q]   <= pipe_we_q[latency_p-1];
      fifo_err_q[wptr_q]  <= pipe_err_q[latency_p-1];
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !acc_err) begin
      if (req_we_i) begin
        for (int k = 0; k < 4; k++) begin
          if (req_mask_i[k]) mem[idx][8*k +: 8] <= req_wdata_i[8*k +: 8];
        end
      end else begin
        mem_rdata_q <= mem[idx];
      end
    end
  end

  assign resp_v_o      = (count_q != 4'd0);
  assign resp_data_o   = resp_v_o ? fifo_data_q[rptr_q] : 32'd0;
  assign resp_we_o     = resp_v_o & fifo_we_q[rptr_q];
  assign resp_err_o    = resp_v_o & fifo_err_q[rptr_q];
  assign exception_o   = exc_q;
  assign outstanding_o = outst_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// tb_data_mem_ctrl : directed self-checking bench for data_mem_ctrl
// Revision         : 1.0
// ============================================================================
module tb_data_mem_ctrl;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int AW    = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_v, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_mask;
  logic        resp_v, yumi, resp_we, resp_err, exc;
  logic [31:0] resp_data;
  logic [3:0]  outst;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pop_cnt = 0;
  int mark_cnt = 0;
  int first_pop_cyc = 0;
  int last_pop_cyc = 0;
  int naccept, max_out;
  logic [33:0] exp_q [$];
  logic [33:0] mon_exp;

  data_mem_ctrl #(
    .imem_addr_width_p(10),
    .dmem_addr_width_p(AW),
    .latency_p(LAT),
    .resp_fifo_depth_p(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_v_i(req_v),
    .req_ready_o(req_ready),
    .req_we_i(req_we),
    .req_addr_i(req_addr),
    .req_wdata_i(req_wdata),
    .req_mask_i(req_mask),
    .resp_v_o(resp_v),
    .resp_yumi_i(yumi),
    .resp_data_o(resp_data),
    .resp_we_o(resp_we),
    .resp_err_o(resp_err),
    .exception_o(exc),
    .outstanding_o(outst)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [33:0] ld(input logic [31:0] d);
    return {2'b00, d};
  endfunction
  function automatic logic [33:0] st();
    return {2'b10, 32'd0};
  endfunction
  function automatic logic [33:0] er(input logic w);
    return {w, 1'b1, 32'd0};
  endfunction

  // Response scoreboard: every consumed response must match the next expected one.
  always @(negedge clk) begin
    if (reset === 1'b1 && resp_v && yumi) begin
      pop_cnt++;
      last_pop_cyc = cyc;
      if (pop_cnt == mark_cnt + 1) first_pop_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("resp_unexpected", 64'(exp_q.size()), 64'd1);
      end else begin
        mon_exp = exp_q.pop_front();
        check("resp", {30'd0, resp_we, resp_err, resp_data}, {30'd0, mon_exp});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] m, input logic [33:0] e);
    int n = 0;
    req_v = 1'b1; req_we = w; req_addr = a; req_wdata = d; req_mask = m;
    while (!req_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) check("req_timeout", 64'(req_ready), 64'd1);
    exp_q.push_back(e);
    step();
  endtask

  task automatic drain();
    int n = 0;
    yumi = 1'b1;
    while ((outst != 4'd0 || resp_v) && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) check("drain_timeout", 64'(outst), 64'd0);
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; req_v = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_mask = '0; yumi = 1'b0;
    repeat (3) step();
    check("rst_ready",  64'(req_ready), 64'd0);
    check("rst_resp_v", 64'(resp_v),    64'd0);
    check("rst_outst",  64'(outst),     64'd0);
    check("rst_exc",    64'(exc),       64'd0);
    check("rst_data",   64'(resp_data), 64'd0);
    check("rst_we_err", 64'({resp_we, resp_err}), 64'd0);
    reset = 1'b1;
    step();
    check("ready_after_rst", 64'(req_ready), 64'd1);

    // Store then load next cycle; load response appears LAT cycles after accept.
    req_v = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'hDEADBEEF; req_mask = 4'hF;
    exp_q.push_back(st());
    step();
    req_we = 1'b0;
    exp_q.push_back(ld(32'hDEADBEEF));
    step();
    req_v = 1'b0;
    check("t1_no_resp_yet", 64'(resp_v), 64'd0);
    check("t1_outst2",      64'(outst),  64'd2);
    step();
    check("t1_store_v",    64'(resp_v),    64'd1);
    check("t1_store_we",   64'(resp_we),   64'd1);
    check("t1_store_data", 64'(resp_data), 64'd0);
    yumi = 1'b1;
    step();
    yumi = 1'b0;
    check("t1_load_v",    64'(resp_v),    64'd1);
    check("t1_load_data", 64'(resp_data), 64'hDEADBEEF);
    check("t1_load_flags", 64'({resp_we, resp_err}), 64'd0);
    step();
    check("t1_hold_data", 64'(resp_data), 64'hDEADBEEF);
    check("t1_outst1",    64'(outst),     64'd1);
    drain();

    // Byte-masked store merge.
    do_req(1'b1, 32'h20, 32'h11223344, 4'hF, st());
    do_req(1'b1, 32'h20, 32'hAABBCCDD, 4'h5, st());
    do_req(1'b0, 32'h20, 32'h0, 4'h0, ld(32'h11BB33DD));
    req_v = 1'b0;
    drain();

    // Misaligned and out-of-range accesses.
    check("t3_exc_before", 64'(exc), 64'd0);
    do_req(1'b0, 32'h22, 32'h0, 4'h0, er(1'b0));
    req_v = 1'b0;
    check("t3_exc_set", 64'(exc), 64'd1);
    do_req(1'b0, 32'h1 << (AW + 2), 32'h0, 4'h0, er(1'b0));
    do_req(1'b1, (32'h1 << (AW + 2)) | 32'h20, 32'h0, 4'hF, er(1'b1));
    do_req(1'b0, 32'h20, 32'h0, 4'h0, ld(32'h11BB33DD));
    req_v = 1'b0;
    drain();
    check("t3_exc_sticky", 64'(exc), 64'd1);

    // Credit limit with the consumer stalled.
    for (int i = 0; i < 5; i++) do_req(1'b1, 32'h40 + 32'(4*i), 32'hA0000000 + 32'(i), 4'hF, st());
    req_v = 1'b0;
    drain();
    yumi = 1'b0;
    naccept = 0;
    req_v = 1'b1; req_we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      req_addr = 32'h40 + 32'(4*naccept);
      if (req_ready) begin
        exp_q.push_back(ld(32'hA0000000 + 32'(naccept)));
        naccept++;
      end
      step();
    end
    check("t4_accepts",     64'(naccept),   64'd4);
    check("t4_ready_full",  64'(req_ready), 64'd0);
    check("t4_outst_full",  64'(outst),     64'd4);
    yumi = 1'b1;
    step();
    yumi = 1'b0;
    check("t4_ready_after_yumi", 64'(req_ready), 64'd1);
    check("t4_outst3",           64'(outst),     64'd3);
    exp_q.push_back(ld(32'hA0000004));
    step();
    req_v = 1'b0;
    check("t4_outst_refill", 64'(outst),     64'd4);
    check("t4_ready_refill", 64'(req_ready), 64'd0);
    drain();

    // Full-throughput stream.
    mark_cnt = pop_cnt;
    max_out = 0;
    for (int i = 0; i < 16; i++) begin
      do_req(1'b0, 32'h40 + 32'(4*(i % 5)), 32'h0, 4'h0, ld(32'hA0000000 + 32'(i % 5)));
      if (int'(outst) > max_out) max_out = int'(outst);
    end
    req_v = 1'b0;
    drain();
    check("t5_resp_count", 64'(pop_cnt - mark_cnt),            64'd16);
    check("t5_span",       64'(last_pop_cyc - first_pop_cyc),  64'd15);
    check("t5_max_outst",  64'(max_out),                       64'(LAT + 1));

    // Reset with requests in flight.
    yumi = 1'b0;
    do_req(1'b0, 32'h10, 32'h0, 4'h0, ld(32'hDEADBEEF));
    do_req(1'b0, 32'h20, 32'h0, 4'h0, ld(32'h11BB33DD));
    do_req(1'b0, 32'h40, 32'h0, 4'h0, ld(32'hA0000000));
    req_v = 1'b0;
    check("t6_outst3", 64'(outst), 64'd3);
    reset = 1'b0;
    step();
    check("t6_rst_resp_v", 64'(resp_v),    64'd0);
    check("t6_rst_outst",  64'(outst),     64'd0);
    check("t6_rst_exc",    64'(exc),       64'd0);
    check("t6_rst_ready",  64'(req_ready), 64'd0);
    check("t6_rst_data",   64'(resp_data), 64'd0);
    exp_q.delete();
    reset = 1'b1;
    repeat (6) step();
    check("t6_no_stale",  64'(resp_v), 64'd0);
    check("t6_outst_idle", 64'(outst), 64'd0);
    yumi = 1'b1;
    do_req(1'b0, 32'h20, 32'h0, 4'h0, ld(32'h11BB33DD));
    do_req(1'b0, 32'h10, 32'h0, 4'h0, ld(32'hDEADBEEF));
    req_v = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Single-port data memory controller that sits directly downstream of the core's memory request port and returns load/store responses to the core's memory response port. Accepts one word-addressed request per cycle through a valid/ready handshake, performs it against a synchronous-read SRAM array, and delivers in-order responses after a fixed pipeline latency through a credit-limited response FIFO. Flags misaligned and out-of-range accesses instead of performing them.

## Interface
- imem_addr_width_p, 10, unused here; kept for parameter symmetry with the core instantiation
- dmem_addr_width_p, 10, word-address width; array holds 2^dmem_addr_width_p 32-bit words
- latency_p, 2, cycles from request acceptance to response visibility; legal 1..4
- resp_fifo_depth_p, 4, maximum outstanding requests (in pipeline plus buffered); legal 2..8

- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-low reset (asserted when 0)
- req_v_i  in  1  request valid
- req_ready_o  out  1  controller can accept a request this cycle
- req_we_i  in  1  1 = store, 0 = load
- req_addr_i  in  32  byte address
- req_wdata_i  in  32  store data
- req_mask_i  in  4  byte-enable for stores; bit k enables bits 8k+7:8k
- resp_v_o  out  1  response valid
- resp_yumi_i  in  1  consumer takes the response this cycle; legal only when resp_v_o=1
- resp_data_o  out  32  load data; 0 for stores and errored requests
- resp_we_o  out  1  echoes req_we_i of the answered request
- resp_err_o  out  1  answered request was misaligned or out of range
- exception_o  out  1  sticky: set by any errored request, cleared only by reset
- outstanding_o  out  4  current outstanding count (debug)

## Operation
- Accept when req_v_i & req_ready_o. req_ready_o = (outstanding < resp_fifo_depth_p), from registered state only; no combinational path from resp_yumi_i or req_v_i.
- Outstanding counter: +1 on accept, −1 on resp_yumi_i, unchanged when both occur in the same cycle.
- Error check at acceptance: err = (req_addr_i[1:0] != 0) | (req_addr_i[31:dmem_addr_width_p+2] != 0). Errored requests never touch the array; they still traverse the pipeline and produce a response with resp_err_o=1, data 0.
- Store (non-errored): array word at req_addr_i[dmem_addr_width_p+1:2] updated on the accept edge, only bytes whose mask bit is 1. Mask 0000 is a legal no-op store that still responds.
- Load (non-errored): array read on the accept edge; read data carried down the pipeline.
- Pipeline: latency_p-stage shift register of {valid, we, err, data}; stage output pushes into the response FIFO. FIFO never overflows because of the credit rule.
- Responses strictly in acceptance order.
- exception_o set the cycle after an errored accept; stays 1 until reset.

## Timing
- Reset (reset=0 at an edge): all pipeline valids, FIFO, counter, exception_o cleared. Outputs during and after reset: req_ready_o=0 while reset=0, resp_v_o=0, resp_err_o=0, resp_data_o=0, resp_we_o=0, exception_o=0, outstanding_o=0. req_ready_o=1 the first cycle after reset deasserts. Array contents are not cleared.
- Reset mid-operation discards all in-flight and buffered responses; no response for them ever appears; stores already accepted remain written.
- Request accepted at edge T with an empty FIFO: resp_v_o=1 during cycle T+latency_p, held with stable fields until resp_yumi_i.
- Back-to-back accepts with resp_yumi_i held 1: one response per cycle, throughput 1/cycle, indefinitely.
- Read-after-write: a load accepted the cycle after a store to the same word returns the stored data. No same-cycle hazard exists (one request per cycle).
- Full: outstanding = resp_fifo_depth_p ⇒ req_ready_o=0; a yumi at edge T lets req_ready_o=1 in cycle T+1.
- req_v_i while req_ready_o=0 is ignored; the requester holds it.

## Test plan
- Reset then store 0xDEADBEEF, mask 1111, to addr 0x10; load 0x10 next cycle -> load response data 0xDEADBEEF, resp_err_o=0, arrives latency_p cycles after its accept.
- Store 0x11223344 mask 1111 to 0x20, then store 0xAABBCCDD mask 0101 to 0x20, load 0x20 -> data 0x11BB33DD.
- Load from 0x22 (misaligned) and from 1<<(dmem_addr_width_p+2) -> both responses resp_err_o=1, data 0; exception_o=1 from the cycle after the first accept; array unchanged.
- Stream 8 loads with resp_yumi_i=0 -> exactly 4 accepted, req_ready_o=0, outstanding_o=4; pulse yumi once -> req_ready_o=1 next cycle, one more accept; all responses in order.
- Stream 16 loads with yumi held 1 -> 16 responses on 16 consecutive cycles, outstanding_o never exceeds latency_p+1.
- Assert reset=0 with 3 outstanding -> resp_v_o=0, outstanding_o=0, exception_o=0 after the edge; no stale responses after release; previously stored data still readable.
